wdt_prescaler: RTL and testbench

Tick generator that sits directly upstream of the watchdog counter and fills its clock-select/scaler slot. It divides one of two event sources by a programmable ratio and emits a single-cycle tick_o that drives the counter's enable_i. Source 0 is every clk_i cycle. Source 1 is each rising edge of a slow reference signal, synchronised internally. After reset the ratio is 0, so tick_o pulses every cycle and watchdog timing is unchanged until software programs a ratio.

---
 rtl/wdt_pkg.sv | 25 ++
 rtl/wdt_edge_sync.sv | 36 +++
 rtl/wdt_prescaler.sv | 172 +++++++++++++++++
 tb/tb_wdt_prescaler.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: prescaler FSM states, default widths and the
// register map / config bit positions used by both the APB wrapper and the
// prescaler.
package wdt_pkg;

  localparam int WDT_PRESC_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FLUSH    = 2'd1,
    RUN      = 2'd2
  } wdt_presc_state_e;

  localparam logic [7:0] WDT_CTRL_OFFSET   = 8'h00;
  localparam logic [7:0] WDT_LOAD_OFFSET   = 8'h04;
  localparam logic [7:0] WDT_COUNT_OFFSET  = 8'h08;
  localparam logic [7:0] WDT_PRESC_OFFSET  = 8'h0C;
  localparam logic [7:0] WDT_STATUS_OFFSET = 8'h10;

  localparam int WDT_CFG_ENABLE_BIT     = 0;
  localparam int WDT_CFG_CLEAR_BIT      = 1;
  localparam int WDT_CFG_CLK_SELECT_BIT = 2;
  localparam int WDT_CFG_SCALER_BIT     = 3;

endpackage

// File: rtl/wdt_edge_sync.sv
// Brings an asynchronous slow reference into the clk_i domain through a flop
// chain and flags each rising edge for exactly one cycle.
module wdt_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   last_q;
  logic                   last_d;

  // Shift the raw level into the chain and remember the previous synced level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], data_i};
    last_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/wdt_prescaler.sv
// Tick generator feeding the watchdog counter enable. Divides either clk_i
// cycles or synchronised ref_clk_i rising edges by (ratio + 1). The ratio is
// double-buffered so a new value only takes effect at a wrap, keeping the
// tick period glitch-free while software reprograms it.
module wdt_prescaler
  import wdt_pkg::*;
#(
  parameter int PRESC_WIDTH = WDT_PRESC_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clk_sel_i,
  input  logic                   ref_clk_i,
  input  logic [PRESC_WIDTH-1:0] presc_value_i,
  input  logic                   presc_update_i,
  input  logic                   clear_i,
  output logic                   tick_o,
  output logic [PRESC_WIDTH-1:0] presc_count_o,
  output logic                   pending_o,
  output logic [PRESC_WIDTH-1:0] active_ratio_o
);

  localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES);

  wdt_presc_state_e       state_q;
  wdt_presc_state_e       state_d;
  logic [FLUSH_W-1:0]     flush_q;
  logic [FLUSH_W-1:0]     flush_d;
  logic                   sel_q;
  logic                   sel_d;
  logic [PRESC_WIDTH-1:0] cnt_q;
  logic [PRESC_WIDTH-1:0] cnt_d;
  logic [PRESC_WIDTH-1:0] shadow_q;
  logic [PRESC_WIDTH-1:0] shadow_d;
  logic [PRESC_WIDTH-1:0] active_q;
  logic [PRESC_WIDTH-1:0] active_d;
  logic                   pending_q;
  logic                   pending_d;
  logic                   tick_q;
  logic                   tick_d;

  logic                   ref_edge;
  logic                   src_event;
  logic                   running;
  logic                   wrap;
  logic                   apply_point;

  wdt_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .data_i(ref_clk_i),
    .edge_o(ref_edge)
  );

  // A disabled RUN cycle never counts; the ratio can be swapped either while
  // idle or on the cycle that schedules a tick.
  assign running     = (state_q == RUN) && enable_i;
  assign src_event   = sel_q ? ref_edge : 1'b1;
  assign wrap        = running && !clear_i && src_event && (cnt_q == active_q);
  assign apply_point = wrap || (state_q == DISABLED);

  // Next-state logic: source select is latched only while idle, and the
  // reference path is flushed before counting so a stale level is not an edge.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    sel_d   = sel_q;
    unique case (state_q)
      DISABLED: begin
        sel_d   = clk_sel_i;
        flush_d = '0;
        if (enable_i) begin
          state_d = clk_sel_i ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (!enable_i) begin
          state_d = DISABLED;
        end else if (flush_q == FLUSH_LAST) begin
          state_d = RUN;
        end else begin
          flush_d = flush_q + FLUSH_W'(1);
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = DISABLED;
        end
      end
      default: begin
        state_d = DISABLED;
      end
    endcase
  end

  // FSM registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DISABLED;
      flush_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      sel_q   <= sel_d;
    end
  end

  // Counter, tick and ratio double-buffer; clear beats a wrap, and an update
  // coinciding with an apply point goes straight into the active ratio.
  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (!running || clear_i) begin
      cnt_d = '0;
    end else if (src_event) begin
      if (cnt_q == active_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PRESC_WIDTH'(1);
      end
    end

    if (presc_update_i) begin
      shadow_d  = presc_value_i;
      pending_d = 1'b1;
    end

    if (apply_point) begin
      if (presc_update_i) begin
        active_d  = presc_value_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign tick_o         = tick_q;
  assign presc_count_o  = cnt_q;
  assign pending_o      = pending_q;
  assign active_ratio_o = active_q;

endmodule

// File: tb/tb_wdt_prescaler.sv
// Randomised and directed bench for wdt_prescaler against a behavioural model
// that tracks the ref history as a sample queue and the flush as a countdown.
module tb_wdt_prescaler;

  localparam int PW = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clkSel;
  logic          refClk;
  logic [PW-1:0] presValue;
  logic          prescUpdate;
  logic          clearCnt;
  logic          tick;
  logic [PW-1:0] prescCount;
  logic          pending;
  logic [PW-1:0] activeRatio;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  logic [PW-1:0] mCnt;
  logic [PW-1:0] mRatio;
  logic [PW-1:0] mShadow;
  bit            mPend;
  bit            mTick;
  bit            mSel;
  bit            mOn;
  int            mFlushLeft;
  bit            refHist[$];

  wdt_prescaler #(
    .PRESC_WIDTH(PW),
    .SYNC_STAGES(S)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .clk_sel_i     (clkSel),
    .ref_clk_i     (refClk),
    .presc_value_i (presValue),
    .presc_update_i(prescUpdate),
    .clear_i       (clearCnt),
    .tick_o        (tick),
    .presc_count_o (prescCount),
    .pending_o     (pending),
    .active_ratio_o(activeRatio)
  );

  always #5 clk = ~clk;

  // One clock edge of the reference behaviour, using the inputs held this cycle.
  task automatic modelStep();
    bit evRef;
    bit ev;
    evRef = refHist[1] && !refHist[0];
    refHist.push_back(refClk);
    void'(refHist.pop_front());
    mTick = 1'b0;
    if (rst) begin
      mOn = 0; mFlushLeft = 0; mCnt = '0; mRatio = '0; mShadow = '0; mPend = 0; mSel = 0;
      refHist = {};
      repeat (S + 1) refHist.push_back(1'b0);
      return;
    end
    ev = mSel ? evRef : 1'b1;
    if (!mOn) begin
      mCnt = '0;
      mSel = clkSel;
      if (prescUpdate) begin mShadow = presValue; mRatio = presValue; mPend = 0; end
      else if (mPend) begin mRatio = mShadow; mPend = 0; end
      if (enable) begin mOn = 1; mFlushLeft = clkSel ? S + 1 : 0; end
    end else begin
      if (prescUpdate) begin mShadow = presValue; mPend = 1; end
      if (!enable) begin mOn = 0; mCnt = '0; end
      else if (mFlushLeft > 0) mFlushLeft--;
      else if (clearCnt) mCnt = '0;
      else if (ev) begin
        if (mCnt == mRatio) begin
          mCnt = '0;
          mTick = 1'b1;
          if (prescUpdate) begin mRatio = presValue; mPend = 0; end
          else if (mPend) begin mRatio = mShadow; mPend = 0; end
        end else begin
          mCnt++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cycleNum++;
  endtask

  task automatic applyReset();
    rst = 1'b1; enable = 1'b0; clkSel = 1'b0; refClk = 1'b0;
    prescUpdate = 1'b0; presValue = '0; clearCnt = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clkSel = 1'b0; refClk = 1'b1;
    prescUpdate = 1'b1; presValue = 8'h33; clearCnt = 1'b1;
    repeat (2) step();
    assertCount++;
    if ({tick, pending, activeRatio, prescCount} !== {1'b0, 1'b0, {PW{1'b0}}, {PW{1'b0}}}) begin
      failCount++;
      $display("[TB] FAIL reset_state got tick=%b pend=%b act=%0d cnt=%0d want all zero", tick, pending, activeRatio, prescCount);
    end
    rst = 1'b0; prescUpdate = 1'b0; clearCnt = 1'b0; enable = 1'b0; refClk = 1'b0;
    step();
    assertCount++;
    if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
      failCount++;
      $display("[TB] FAIL reset_idle cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
               cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
    end
  endtask

  task automatic test_ratio_zero();
    applyReset();
    enable = 1'b1; clkSel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL ratio_zero cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
      assertCount++;
      if (tick !== (i >= 1)) begin
        failCount++;
        $display("[TB] FAIL ratio_zero_tick i=%0d got %b want %b", i, tick, (i >= 1));
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_update_disabled();
    applyReset();
    presValue = 8'd4; prescUpdate = 1'b1;
    step();
    prescUpdate = 1'b0;
    assertCount++;
    if ({pending, activeRatio} !== {1'b0, 8'd4}) begin
      failCount++;
      $display("[TB] FAIL update_disabled_apply got pend=%b act=%0d want pend=0 act=4", pending, activeRatio);
    end
    enable = 1'b1; clkSel = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL div5 cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
      assertCount++;
      if ({tick, prescCount} !== {(k > 0 && k % 5 == 0), PW'(k % 5)}) begin
        failCount++;
        $display("[TB] FAIL div5_seq k=%0d got tick=%b cnt=%0d want tick=%b cnt=%0d",
                 k, tick, prescCount, (k > 0 && k % 5 == 0), k % 5);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_update_pending();
    bit sentA = 0;
    bit sentB = 0;
    bit justA;
    bit justB;
    applyReset();
    presValue = 8'd9; prescUpdate = 1'b1;
    step();
    prescUpdate = 1'b0; enable = 1'b1; clkSel = 1'b0;
    for (int i = 0; i < 60; i++) begin
      prescUpdate = 1'b0; justA = 0; justB = 0;
      if (!sentA && mOn && mCnt == 8'd3 && mRatio == 8'd9) begin
        presValue = 8'd2; prescUpdate = 1'b1; sentA = 1; justA = 1;
      end else if (sentA && !sentB && mRatio == 8'd2 && mCnt == 8'd2 && !mPend) begin
        presValue = 8'd5; prescUpdate = 1'b1; sentB = 1; justB = 1;
      end
      step();
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL update_pending cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
      if (justA) begin
        assertCount++;
        if ({pending, activeRatio} !== {1'b1, 8'd9}) begin
          failCount++;
          $display("[TB] FAIL pending_set got pend=%b act=%0d want pend=1 act=9", pending, activeRatio);
        end
      end
      if (justB) begin
        assertCount++;
        if ({tick, pending, activeRatio} !== {1'b1, 1'b0, 8'd5}) begin
          failCount++;
          $display("[TB] FAIL update_at_wrap got tick=%b pend=%b act=%0d want tick=1 pend=0 act=5", tick, pending, activeRatio);
        end
      end
    end
    prescUpdate = 1'b0; enable = 1'b0;
    step();
  endtask

  task automatic test_ref_source();
    int tickTotal = 0;
    applyReset();
    presValue = 8'd1; prescUpdate = 1'b1; clkSel = 1'b1;
    step();
    prescUpdate = 1'b0;
    for (int i = 0; i < 130; i++) begin
      refClk = ((i + 16) % 20) < 10;
      enable = (i >= 4);
      clkSel = (i % 7 == 0) ? 1'b0 : 1'b1;
      if (i == 4) clkSel = 1'b1;
      step();
      tickTotal += int'(tick);
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL ref_source cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
    end
    assertCount++;
    if (tickTotal != 3) begin
      failCount++;
      $display("[TB] FAIL ref_tick_total got %0d want 3", tickTotal);
    end
    enable = 1'b0; refClk = 1'b0;
    step();
  endtask

  task automatic test_clear_disable();
    int  phase = 0;
    int  sinceClear = -1;
    int  tickGap = -1;
    bit  chkClear;
    bit  chkDis;
    applyReset();
    presValue = 8'd3; prescUpdate = 1'b1;
    step();
    prescUpdate = 1'b0; enable = 1'b1; clkSel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      clearCnt = 1'b0; chkClear = 0; chkDis = 0;
      clkSel = (phase <= 1 && i > 0) ? (i % 2 == 1) : 1'b0;
      if (phase == 0 && mOn && mCnt == 8'd3) begin
        clearCnt = 1'b1; phase = 1; chkClear = 1;
      end else if (phase == 1 && tickGap >= 0 && mCnt == 8'd2) begin
        enable = 1'b0; clkSel = 1'b0; phase = 2; chkDis = 1;
      end else if (phase == 2) begin
        enable = 1'b1; clkSel = 1'b0; phase = 3;
      end
      step();
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL clear_disable cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
      if (chkClear || chkDis) begin
        assertCount++;
        if ({tick, prescCount} !== {1'b0, {PW{1'b0}}}) begin
          failCount++;
          $display("[TB] FAIL %s got tick=%b cnt=%0d want tick=0 cnt=0", chkClear ? "clear_at_wrap" : "disable_mid", tick, prescCount);
        end
      end
      if (chkClear) sinceClear = 0;
      else if (sinceClear >= 0) begin
        sinceClear++;
        if (tick && tickGap < 0) tickGap = sinceClear;
      end
    end
    assertCount++;
    if (tickGap != 4) begin
      failCount++;
      $display("[TB] FAIL clear_gap got %0d want 4", tickGap);
    end
    enable = 1'b0; clkSel = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    applyReset();
    presValue = 8'd7; prescUpdate = 1'b1;
    step();
    prescUpdate = 1'b0; enable = 1'b1; clkSel = 1'b0;
    repeat (6) step();
    assertCount++;
    if ({activeRatio, prescCount} !== {8'd7, 8'd5}) begin
      failCount++;
      $display("[TB] FAIL mid_count_setup got act=%0d cnt=%0d want act=7 cnt=5", activeRatio, prescCount);
    end
    rst = 1'b1; prescUpdate = 1'b1; presValue = 8'd12;
    step();
    rst = 1'b0; prescUpdate = 1'b0;
    assertCount++;
    if ({tick, pending, activeRatio, prescCount} !== {1'b0, 1'b0, {PW{1'b0}}, {PW{1'b0}}}) begin
      failCount++;
      $display("[TB] FAIL reset_mid_count got tick=%b pend=%b act=%0d cnt=%0d want all zero", tick, pending, activeRatio, prescCount);
    end
    enable = 1'b1; clkSel = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    assertCount++;
    if ({tick, pending, activeRatio, prescCount} !== {1'b0, 1'b0, {PW{1'b0}}, {PW{1'b0}}}) begin
      failCount++;
      $display("[TB] FAIL reset_mid_flush got tick=%b pend=%b act=%0d cnt=%0d want all zero", tick, pending, activeRatio, prescCount);
    end
    clkSel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL after_reset cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_max_ratio();
    int tickTotal = 0;
    applyReset();
    presValue = 8'd255; prescUpdate = 1'b1;
    step();
    prescUpdate = 1'b0; enable = 1'b1; clkSel = 1'b0;
    for (int k = 0; k < 520; k++) begin
      step();
      tickTotal += int'(tick);
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL max_ratio cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
    end
    assertCount++;
    if (tickTotal != 2) begin
      failCount++;
      $display("[TB] FAIL max_ratio_ticks got %0d want 2", tickTotal);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_random();
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      clkSel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) refClk = ~refClk;
      prescUpdate = ($urandom_range(0, 15) == 0);
      presValue = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 4));
      clearCnt = ($urandom_range(0, 24) == 0);
      step();
      assertCount++;
      if ({tick, pending, activeRatio, prescCount} !== {mTick, mPend, mRatio, mCnt}) begin
        failCount++;
        $display("[TB] FAIL random cyc=%0d got tick=%b pend=%b act=%0d cnt=%0d want tick=%b pend=%b act=%0d cnt=%0d",
                 cycleNum, tick, pending, activeRatio, prescCount, mTick, mPend, mRatio, mCnt);
      end
    end
    rst = 1'b0; prescUpdate = 1'b0; clearCnt = 1'b0; enable = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clkSel = 1'b0; refClk = 1'b0;
    prescUpdate = 1'b0; presValue = '0; clearCnt = 1'b0;
    mCnt = '0; mRatio = '0; mShadow = '0; mPend = 0; mTick = 0; mSel = 0; mOn = 0; mFlushLeft = 0;
    repeat (S + 1) refHist.push_back(1'b0);
    test_reset();
    test_ratio_zero();
    test_update_disabled();
    test_update_pending();
    test_ref_source();
    test_clear_disable();
    test_reset_mid();
    test_max_ratio();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
